apb_master_sched: RTL and testbench
===================================

# apb_master_sched

Two-requester APB master scheduler: it arbitrates between requester ports 0 and 1 and decodes the address to one of three one-hot slave selects. It sequences the APB SETUP/ACCESS protocol on the shared APB bus and returns read data and the error flag to the requester that issued the transfer. It drives the bus signals carried by `apb_intf` (PADDR, PSEL[2:0], PWRITE, PWDATA, PENABLE) and samples PRDATA, PREADY and Pslverr.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT_CYC`, 16, maximum number of ACCESS cycles before abort. Used only when `APB_SCHED_TIMEOUT_EN` is defined; range 1..255.

Ports (N = 0, 1; one full set per requester):
- `clk` in 1: the only clock; all logic is on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1: requester N has a transfer pending; held until `reqN_ready`.
- `reqN_ready` out 1: one-cycle pulse when the request is accepted.
- `reqN_addr` in ADDR_W: transfer address.
- `reqN_write` in 1: 1 = write, 0 = read.
- `reqN_wdata` in DATA_W: write data.
- `rspN_valid` out 1: one-cycle pulse when the transfer completes.
- `rspN_rdata` out DATA_W: read data; 0 for writes and on error.
- `rspN_err` out 1: error flag, valid while `rspN_valid` is high.
- `PADDR` out 32, `PSEL` out 3, `PWRITE` out 1, `PWDATA` out 32, `PENABLE` out 1: APB master outputs, all registered.
- `PRDATA` in 32, `PREADY` in 1, `Pslverr` in 1: APB slave responses.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- Reset values: all outputs 0, state IDLE, round-robin pointer `last` = 1 (requester 0 wins the first contest).
- IDLE:
  - With no valid request, stay in IDLE.
  - With one valid request, grant it.
  - With both valid, grant the requester other than `last`, then update `last`.
  - On grant: pulse `reqN_ready`, latch addr/write/wdata and the granted ID.
- Address decode on `addr[29:28]`:
  - 0 → PSEL=3'b001; 1 → 3'b010; 2 → 3'b100.
  - 3 → no slave: skip the APB bus and go straight to RESP with err=1, rdata=0.
- SETUP (one cycle): PSEL = decoded value, PENABLE=0; PADDR, PWRITE and PWDATA driven from the latched values.
- ACCESS: PENABLE=1, bus signals held stable. Remain in ACCESS while PREADY=0.
- When PREADY=1 in ACCESS:
  - Capture PRDATA (reads only) and Pslverr.
  - Next cycle: PSEL=0, PENABLE=0, state RESP.
- RESP (one cycle): pulse `rspN_valid` for the granted requester, with rdata/err. Then return to IDLE.
- PADDR, PWRITE and PWDATA hold their last values after a transfer; only PSEL and PENABLE return to 0.
- A request that arrives while the scheduler is busy waits; `reqN_valid` must stay asserted until it is accepted.

## Timing
- Zero-wait-state transfer: grant at cycle T0 (IDLE), SETUP at T1, ACCESS at T2 with PREADY=1, `rsp_valid` at T3.
- Each wait state (PREADY=0) adds one cycle.
- Minimum spacing between transfers is 4 cycles: RESP→IDLE costs one cycle, and the grant is never issued in RESP.
- Decode miss: grant at T0, `rsp_valid` with err=1 at T1.
- Pslverr is sampled only in the cycle where PREADY=1 during ACCESS.
- If `resetn` is asserted mid-transfer, all outputs clear immediately: the APB transfer is dropped and no response is issued.

## Configuration
- `APB_SCHED_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYC, the transfer aborts: PSEL and PENABLE drop next cycle, then RESP with err=1 and rdata=0.
  - PREADY and PRDATA arriving after the abort are ignored.
- `APB_SCHED_TIMEOUT_EN` not defined: no counter is built, ACCESS waits indefinitely for PREADY, and `TIMEOUT_CYC` is ignored.

## Test plan
- Req0 read, addr 0x1000_0004, PREADY=1 immediately, PRDATA=0xDEAD_BEEF → PSEL=3'b010 at T1/T2, PENABLE=1 at T2 only; `rsp0_valid` at T3 with rdata=0xDEAD_BEEF, err=0.
- Both requesters valid from reset with writes to 0x0000_0010 and 0x2000_0020 → req0 served first (PSEL=001), then req1 (PSEL=100); alternation continues while both stay valid.
- Req1 write, addr 0x0000_0008, PREADY low for 3 cycles, Pslverr=1 with PREADY → ACCESS lasts 4 cycles with PADDR/PWDATA stable; `rsp1_err`=1, rdata=0.
- Req0 addr 0x3000_0000 → no PSEL ever asserted; `rsp0_valid` one cycle after grant, err=1.
- With `APB_SCHED_TIMEOUT_EN` and TIMEOUT_CYC=4, PREADY held low → abort after 4 ACCESS cycles, err=1. Without the macro: still in ACCESS after 100 cycles.
- `resetn` low during ACCESS → PSEL, PENABLE and `rsp*_valid` go to 0 asynchronously. After release, a new req0 read completes normally.

Source files
------------

// File: rtl/apb_master_sched.sv
// apb_master_sched: two-requester round-robin APB master with a 3-way address decode.
// Define APB_SCHED_TIMEOUT_EN to build the ACCESS-phase timeout (TIMEOUT_CYC cycles).
module apb_master_sched #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic [2:0]        PSEL,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              Pslverr
);
  // state  | meaning
  // IDLE   | arbitrate, grant and latch a request
  // SETUP  | PSEL asserted, PENABLE low
  // ACCESS | PENABLE high, waiting for PREADY
  // RESP   | rsp_valid pulse to the granted requester
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state;
  logic              last;
  logic              gnt_id;
  logic              gnt1;
  logic [ADDR_W-1:0] gnt_addr;
  logic [2:0]        dec_sel;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

`ifdef APB_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tcnt;
`endif

  // last=1 favours requester 0 on a contest, last=0 favours requester 1
  assign gnt1     = req1_valid & (~req0_valid | ~last);
  assign gnt_addr = gnt1 ? req1_addr : req0_addr;

  always_comb begin
    dec_sel = 3'b000;
    case (gnt_addr[29:28])
      2'd0:    dec_sel = 3'b001;
      2'd1:    dec_sel = 3'b010;
      2'd2:    dec_sel = 3'b100;
      default: dec_sel = 3'b000;
    endcase
  end

  assign rsp0_rdata = rsp_rdata;
  assign rsp1_rdata = rsp_rdata;
  assign rsp0_err   = rsp_err;
  assign rsp1_err   = rsp_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last       <= 1'b1;
      gnt_id     <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      PADDR      <= '0;
      PSEL       <= 3'b000;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      PENABLE    <= 1'b0;
`ifdef APB_SCHED_TIMEOUT_EN
      tcnt       <= 8'd0;
`endif
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt_id     <= gnt1;
            req0_ready <= ~gnt1;
            req1_ready <= gnt1;
            if (req0_valid && req1_valid) last <= gnt1;
            if (dec_sel == 3'b000) begin
              // decode miss never touches the bus
              rsp_rdata  <= '0;
              rsp_err    <= 1'b1;
              rsp0_valid <= ~gnt1;
              rsp1_valid <= gnt1;
              state      <= RESP;
            end else begin
              PADDR  <= gnt_addr;
              PWRITE <= gnt1 ? req1_write : req0_write;
              PWDATA <= gnt1 ? req1_wdata : req0_wdata;
              PSEL   <= dec_sel;
              state  <= SETUP;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
`ifdef APB_SCHED_TIMEOUT_EN
          tcnt    <= 8'd0;
`endif
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL       <= 3'b000;
            PENABLE    <= 1'b0;
            rsp_rdata  <= (PWRITE || Pslverr) ? '0 : PRDATA;
            rsp_err    <= Pslverr;
            rsp0_valid <= ~gnt_id;
            rsp1_valid <= gnt_id;
            state      <= RESP;
          end
`ifdef APB_SCHED_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            PSEL       <= 3'b000;
            PENABLE    <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b1;
            rsp0_valid <= ~gnt_id;
            rsp1_valid <= gnt_id;
            state      <= RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_sched.sv
// Directed bench for apb_master_sched: vector table plus arbitration, timeout and reset sequences.
module tb_apb_master_sched;
  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req0_ready, req0_write, rsp0_valid, rsp0_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_ready, req1_write, rsp1_valid, rsp1_err;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [2:0]  PSEL;
  logic        PWRITE, PENABLE, PREADY, Pslverr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_master_sched #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_write(req0_write), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_write(req1_write), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PADDR(PADDR), .PSEL(PSEL), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .Pslverr(Pslverr)
  );

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [2:0]  exp_psel;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          acc, lat, rdy_at;
    logic [2:0]  psel_or;
    logic        got, setup_ok, stable_ok, wrong;
    logic [31:0] r_rdata;
    logic        r_err;
    acc = 0; lat = 0; rdy_at = 0; psel_or = 3'b000;
    got = 1'b0; setup_ok = 1'b1; stable_ok = 1'b1; wrong = 1'b0;
    r_rdata = 32'hX; r_err = 1'bx;
    if (v.id) begin
      req1_valid = 1'b1; req1_addr = v.addr; req1_write = v.wr; req1_wdata = v.wdata;
    end else begin
      req0_valid = 1'b1; req0_addr = v.addr; req0_write = v.wr; req0_wdata = v.wdata;
    end
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (v.id ? req1_ready : req0_ready) begin
        rdy_at = c;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      if (v.id ? req0_ready : req1_ready) wrong = 1'b1;
      psel_or |= PSEL;
      if (PSEL != 3'b000 && !PENABLE) begin
        if (PADDR !== v.addr || PWRITE !== v.wr || PSEL !== v.exp_psel) setup_ok = 1'b0;
        if (v.wr && PWDATA !== v.wdata) setup_ok = 1'b0;
      end
      if (PSEL != 3'b000 && PENABLE) begin
        acc++;
        if (PADDR !== v.addr || PSEL !== v.exp_psel) stable_ok = 1'b0;
        if (v.wr && PWDATA !== v.wdata) stable_ok = 1'b0;
      end
      PREADY  = (PSEL != 3'b000) && PENABLE && (acc > v.waits);
      PRDATA  = v.prdata;
      Pslverr = PREADY & v.slverr;
      if (rsp0_valid || rsp1_valid) begin
        got = 1'b1;
        lat = c;
        if (v.id ? rsp0_valid : rsp1_valid) wrong = 1'b1;
        r_rdata = v.id ? rsp1_rdata : rsp0_rdata;
        r_err   = v.id ? rsp1_err : rsp0_err;
      end
    end
    PREADY = 1'b0; Pslverr = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d_rdata", idx), 64'(r_rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d_err", idx), 64'(r_err), 64'(v.exp_err));
    chk($sformatf("v%0d_psel", idx), 64'(psel_or), 64'(v.exp_psel));
    chk($sformatf("v%0d_access_cycles", idx), 64'(acc),
        64'((v.exp_psel == 3'b000) ? 0 : v.waits + 1));
    chk($sformatf("v%0d_ready_at", idx), 64'(rdy_at), 64'd1);
    chk($sformatf("v%0d_setup_ok", idx), 64'(setup_ok), 64'd1);
    chk($sformatf("v%0d_stable_ok", idx), 64'(stable_ok), 64'd1);
    chk($sformatf("v%0d_wrong_port", idx), 64'(wrong), 64'd0);
  endtask

  initial begin
    logic        q_id[$];
    int          q_at[$];
    logic [2:0]  q_psel[$];
    int          lat;
    logic        stuck;
    logic [31:0] r_rdata;
    logic        r_err;

    vt[0] = '{1'b0, 32'h1000_0004, 1'b0, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'hDEAD_BEEF, 3};
    vt[1] = '{1'b1, 32'h0000_0008, 1'b1, 32'h1234_5678, 3, 1'b1, 32'h7777_7777, 3'b001, 1'b1, 32'h0,         6};
    vt[2] = '{1'b0, 32'h3000_0000, 1'b0, 32'h0,         0, 1'b0, 32'h9999_9999, 3'b000, 1'b1, 32'h0,         1};
    vt[3] = '{1'b1, 32'h2000_0020, 1'b0, 32'h0,         1, 1'b0, 32'hCAFE_0001, 3'b100, 1'b0, 32'hCAFE_0001, 4};
    vt[4] = '{1'b0, 32'h0000_0010, 1'b1, 32'h0BAD_CAFE, 0, 1'b0, 32'hAAAA_5555, 3'b001, 1'b0, 32'h0,         3};
    vt[5] = '{1'b1, 32'h1FFF_FFFC, 1'b0, 32'h0,         2, 1'b1, 32'h1111_1111, 3'b010, 1'b1, 32'h0,         5};
    vt[6] = '{1'b1, 32'hF000_0000, 1'b1, 32'h5A5A_5A5A, 0, 1'b0, 32'h0,         3'b000, 1'b1, 32'h0,         1};
    vt[7] = '{1'b0, 32'hC000_1000, 1'b0, 32'h0,         0, 1'b0, 32'h0BAD_F00D, 3'b001, 1'b0, 32'h0BAD_F00D, 3};

    resetn = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_write = 1'b0; req0_wdata = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_write = 1'b0; req1_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; Pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_psel_penable", {61'd0, PSEL} | {63'd0, PENABLE} << 3, 64'd0);
    chk("reset_bus", {PADDR, PWDATA} | {63'd0, PWRITE}, 64'd0);
    chk("reset_handshake", {60'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 64'd0);
    chk("reset_rsp", {rsp0_rdata, rsp1_rdata} | {62'd0, rsp0_err, rsp1_err}, 64'd0);
    resetn = 1'b1;

    // both requesters held valid from reset: req0 first, then strict alternation
    req0_valid = 1'b1; req0_addr = 32'h0000_0010; req0_write = 1'b1; req0_wdata = 32'hA0A0_A0A0;
    req1_valid = 1'b1; req1_addr = 32'h2000_0020; req1_write = 1'b1; req1_wdata = 32'hB1B1_B1B1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (req0_ready) begin q_id.push_back(1'b0); q_at.push_back(c); end
      if (req1_ready) begin q_id.push_back(1'b1); q_at.push_back(c); end
      if (PSEL != 3'b000 && !PENABLE) q_psel.push_back(PSEL);
      PREADY = (PSEL != 3'b000) && PENABLE;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; PREADY = 1'b0;
    @(negedge clk);
    chk("alt_grant_count", 64'(q_id.size()), 64'd4);
    chk("alt_setup_count", 64'(q_psel.size()), 64'd4);
    for (int i = 0; i < 4 && i < q_id.size() && i < q_psel.size(); i++) begin
      chk($sformatf("alt_id%0d", i), 64'(q_id[i]), 64'(i % 2));
      chk($sformatf("alt_at%0d", i), 64'(q_at[i]), 64'(1 + 4 * i));
      chk($sformatf("alt_psel%0d", i), 64'(q_psel[i]), (i % 2 == 0) ? 64'h1 : 64'h4);
    end

    // slave never ready
    req0_valid = 1'b1; req0_addr = 32'h0000_0000; req0_write = 1'b0;
    PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
`ifdef APB_SCHED_TIMEOUT_EN
    lat = 0; r_rdata = 32'hX; r_err = 1'bx;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (req0_ready) req0_valid = 1'b0;
      if (rsp0_valid) begin lat = c; r_rdata = rsp0_rdata; r_err = rsp0_err; end
    end
    chk("timeout_latency", 64'(lat), 64'd6);
    chk("timeout_err", 64'(r_err), 64'd1);
    chk("timeout_rdata", 64'(r_rdata), 64'd0);
    @(negedge clk);
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
`else
    stuck = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (req0_ready) req0_valid = 1'b0;
      if (c >= 2 && !(PSEL == 3'b001 && PENABLE)) stuck = 1'b0;
      if (rsp0_valid || rsp1_valid) stuck = 1'b0;
    end
    chk("no_timeout_stuck", 64'(stuck), 64'd1);
`endif

    // asynchronous reset in the middle of ACCESS
    chk("pre_reset_access", {61'd0, PSEL} | {60'd0, PENABLE, 3'b000}, 64'h9);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_psel_penable", {61'd0, PSEL} | {60'd0, PENABLE, 3'b000}, 64'd0);
    chk("async_reset_rsp_valid", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
